// File: rtl/i2c_sht40_responder.sv
// i2c_sht40_responder: I2C target emulating an SHT40 humidity/temperature sensor
// Ports:
//   clk, rst                 system clock (>= 20x SCL), async active-high reset
//   Scl_In, Sda_In           raw bus lines, synchronised internally
//   Sda_Out                  open-drain SDA control (1 = release, 0 = pull low)
//   Temp_Value, RH_Value     raw words latched when a command is accepted
//   Cmd_Out, Cmd_Valid       last accepted command and its one-clk strobe
//   Meas_Busy, Data_Ready    busy window after a command, result available
module i2c_sht40_responder #(
   parameter logic [6:0] ADDRESS     = 7'h44,
   parameter int         MEAS_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Scl_In,
   input  logic        Sda_In,
   output logic        Sda_Out,
   input  logic [15:0] Temp_Value,
   input  logic [15:0] RH_Value,
   output logic [7:0]  Cmd_Out,
   output logic        Cmd_Valid,
   output logic        Meas_Busy,
   output logic        Data_Ready
);
   localparam int CW = $clog2(MEAS_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX_BYTE, TX_ACK, WAIT_STOP} state_t;
   function automatic logic [7:0] crc8(input logic [15:0] d);
      logic [7:0] c;
      c = 8'hFF;
      for (int i = 15; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h31 : 8'h00);
      return c;
   endfunction
   state_t state, state_n;
   logic [1:0] scl_s, sda_s;
   logic scl_q, sda_q, scl, sda, scl_rise, scl_fall, start, stop;
   logic [3:0] bit_cnt;
   logic [7:0] shreg, tx_frame, crc_t, crc_rh;
   logic [2:0] idx;
   logic [15:0] t_q, rh_q;
   logic [CW-1:0] busy_cnt;
   logic rd_done, sda_n, last, addr_ok, cmd_ok, accept;
   assign scl      = scl_s[1];
   assign sda      = sda_s[1];
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start    = scl & scl_q & sda_q & ~sda;
   assign stop     = scl & scl_q & ~sda_q & sda;
   // bit_cnt reaches 8 after the eighth rise; the following fall ends the byte
   assign last     = bit_cnt == 4'd8;
   assign addr_ok  = shreg[7:1] == ADDRESS && (shreg[0] ? Data_Ready : !Meas_Busy);
   assign cmd_ok   = shreg == 8'hFD || shreg == 8'hF6 || shreg == 8'hE0;
   assign accept   = state == CMD_ACK && scl_fall;
   assign crc_t    = crc8(t_q);
   assign crc_rh   = crc8(rh_q);
   assign tx_frame = idx == 3'd0 ? t_q[15:8] : idx == 3'd1 ? t_q[7:0] : idx == 3'd2 ? crc_t :
                     idx == 3'd3 ? rh_q[15:8] : idx == 3'd4 ? rh_q[7:0] : idx == 3'd5 ? crc_rh : 8'hFF;
   // idle-high reset values keep the release of rst from looking like a START
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         scl_s <= 2'b11;
         sda_s <= 2'b11;
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_s <= {scl_s[0], Scl_In};
         sda_s <= {sda_s[0], Sda_In};
         scl_q <= scl;
         sda_q <= sda;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      sda_n   = Sda_Out;
      if (start || stop) begin
         state_n = stop ? IDLE : ADDR;
         sda_n   = 1'b1;
      end else if (scl_fall) begin
         sda_n = 1'b1;
         case (state)
            ADDR: begin
               state_n = last ? (addr_ok ? ADDR_ACK : WAIT_STOP) : ADDR;
               sda_n   = !(last && addr_ok);
            end
            ADDR_ACK: begin
               state_n = shreg[0] ? TX_BYTE : CMD;
               sda_n   = !shreg[0] || t_q[15];
            end
            CMD: begin
               state_n = last ? (cmd_ok ? CMD_ACK : WAIT_STOP) : CMD;
               sda_n   = !(last && cmd_ok);
            end
            CMD_ACK: state_n = WAIT_STOP;
            TX_BYTE: begin
               state_n = last ? TX_ACK : TX_BYTE;
               sda_n   = last || tx_frame[3'd7 - bit_cnt[2:0]];
            end
            // idx was already advanced on the ACK rise, so this is the next frame's MSB
            TX_ACK: begin
               state_n = TX_BYTE;
               sda_n   = tx_frame[7];
            end
            default: ;
         endcase
      end else if (scl_rise && state == TX_ACK && sda) state_n = WAIT_STOP;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         Sda_Out    <= 1'b1;
         Cmd_Out    <= 8'h00;
         Cmd_Valid  <= 1'b0;
         Meas_Busy  <= 1'b0;
         Data_Ready <= 1'b0;
         bit_cnt    <= 4'd0;
         shreg      <= 8'h00;
         idx        <= 3'd0;
         t_q        <= 16'h0000;
         rh_q       <= 16'h0000;
         busy_cnt   <= '0;
         rd_done    <= 1'b0;
      end else begin
         Sda_Out   <= sda_n;
         Cmd_Valid <= accept;
         if (start || stop) bit_cnt <= 4'd0;
         else if (scl_rise && (state == ADDR || state == CMD || state == TX_BYTE)) bit_cnt <= bit_cnt + 4'd1;
         else if (scl_fall && (state == ADDR_ACK || state == TX_ACK)) bit_cnt <= 4'd0;
         if (scl_rise && (state == ADDR || state == CMD)) shreg <= {shreg[6:0], sda};
         if (scl_fall && state == ADDR_ACK) idx <= 3'd0;
         else if (scl_rise && state == TX_ACK && !sda && idx != 3'd6) idx <= idx + 3'd1;
         rd_done <= stop ? 1'b0 : rd_done || (scl_rise && state == TX_ACK);
         if (accept) begin
            t_q        <= Temp_Value;
            rh_q       <= RH_Value;
            Cmd_Out    <= shreg;
            Meas_Busy  <= 1'b1;
            Data_Ready <= 1'b0;
            busy_cnt   <= CW'(MEAS_CYCLES);
         end else if (Meas_Busy) begin
            busy_cnt <= busy_cnt - CW'(1);
            if (busy_cnt == CW'(1)) begin
               Meas_Busy  <= 1'b0;
               Data_Ready <= 1'b1;
            end
         end else if (stop && rd_done) Data_Ready <= 1'b0;
      end
endmodule

// File: tb/tb_i2c_sht40_responder.sv
// tb_i2c_sht40_responder: randomized I2C master against a transaction-level SHT40 model
`timescale 1ns/1ps
module tb_i2c_sht40_responder;
   localparam logic [6:0] ADDR = 7'h44;
   localparam int MEAS = 1000;
   localparam int H = 10;
   logic clk = 0, rst = 1, m_scl = 1, m_sda = 1;
   logic [15:0] temp_v = 0, rh_v = 0;
   logic sda_out, cmd_valid, meas_busy, data_ready, bus_sda;
   logic [7:0] cmd_out;
   assign bus_sda = m_sda & sda_out;
   i2c_sht40_responder #(.ADDRESS(ADDR), .MEAS_CYCLES(MEAS)) dut (
      .clk(clk), .rst(rst), .Scl_In(m_scl), .Sda_In(bus_sda), .Sda_Out(sda_out),
      .Temp_Value(temp_v), .RH_Value(rh_v), .Cmd_Out(cmd_out), .Cmd_Valid(cmd_valid),
      .Meas_Busy(meas_busy), .Data_Ready(data_ready)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0, cv_cnt = 0, busy_cyc = 0;
   always @(negedge clk) begin
      if (cmd_valid) cv_cnt++;
      if (meas_busy) busy_cyc++;
   end
   logic m_busy = 0, m_ready = 0;
   logic [7:0] m_cmd = 0;
   logic [15:0] m_t = 0, m_rh = 0;
   int m_cv = 0, m_bcyc = 0;
   function automatic logic [7:0] crc_ref(input logic [15:0] w);
      logic [7:0] c;
      c = 8'hFF;
      for (int b = 1; b >= 0; b--) begin
         c ^= w[b*8 +: 8];
         for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
      end
      return c;
   endfunction
   function automatic logic [7:0] frame(input int i);
      logic [7:0] f [6];
      f = '{m_t[15:8], m_t[7:0], crc_ref(m_t), m_rh[15:8], m_rh[7:0], crc_ref(m_rh)};
      return i < 6 ? f[i] : 8'hFF;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic bit_io(input logic b, output logic r);
      m_sda = b;
      clks(H - 2);
      m_scl = 1;
      clks(H / 2);
      r = bus_sda;
      clks(H / 2);
      m_scl = 0;
      clks(2);
   endtask
   task automatic i2c_start;
      m_sda = 1;
      clks(H);
      m_scl = 1;
      clks(H);
      m_sda = 0;
      clks(H);
      m_scl = 0;
      clks(2);
   endtask
   task automatic i2c_stop;
      m_sda = 0;
      clks(H);
      m_scl = 1;
      clks(H);
      m_sda = 1;
      clks(H);
   endtask
   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(b[i], r);
      bit_io(1'b1, ack);
   endtask
   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
      bit_io(nack, r);
   endtask
   task automatic do_write(input logic [6:0] a, input logic [7:0] c, input logic extra,
                           input logic [15:0] t, input logic [15:0] h);
      logic ack, ok, cok;
      temp_v = t;
      rh_v = h;
      i2c_start;
      write_byte({a, 1'b0}, ack);
      ok = a == ADDR && !m_busy;
      chk("waddr", ack, !ok);
      write_byte(c, ack);
      cok = ok && (c == 8'hFD || c == 8'hF6 || c == 8'hE0);
      chk("wcmd", ack, !cok);
      if (cok) begin
         m_busy = 1;
         m_ready = 0;
         m_cmd = c;
         m_t = t;
         m_rh = h;
         m_cv++;
         m_bcyc += MEAS;
      end
      if (extra) begin
         write_byte(8'($urandom), ack);
         chk("wextra", ack, 1);
      end
      i2c_stop;
      temp_v = 16'($urandom);
      rh_v = 16'($urandom);
      chk("cmd_out", cmd_out, m_cmd);
      chk("cv_cnt", cv_cnt, m_cv);
      chk("busy", meas_busy, m_busy);
   endtask
   task automatic do_read(input logic [6:0] a, input int n, input int n2);
      logic ack, ok, any;
      logic [7:0] d;
      any = 0;
      for (int pass = 0; pass < (n2 > 0 ? 2 : 1); pass++) begin
         i2c_start;
         write_byte({a, 1'b1}, ack);
         ok = a == ADDR && m_ready;
         chk("raddr", ack, !ok);
         for (int i = 0; i < (pass == 0 ? n : n2); i++) begin
            read_byte(i == (pass == 0 ? n : n2) - 1, d);
            chk($sformatf("rdata%0d", i), d, ok ? frame(i) : 8'hFF);
         end
         any |= ok;
      end
      i2c_stop;
      if (any) m_ready = 0;
      chk("ready", data_ready, m_ready);
   endtask
   task automatic wait_meas;
      clks(MEAS + 20);
      if (m_busy) begin
         m_busy = 0;
         m_ready = 1;
      end
      chk("busy_done", meas_busy, m_busy);
      chk("ready_set", data_ready, m_ready);
      chk("busy_cyc", busy_cyc, m_bcyc);
   endtask
   initial begin
      logic r;
      logic [2:0] bits;
      clks(3);
      chk("rst_sda", sda_out, 1);
      chk("rst_ready", data_ready, 0);
      chk("rst_busy", meas_busy, 0);
      chk("rst_cmd", cmd_out, 0);
      chk("rst_cv", cmd_valid, 0);
      rst = 0;
      clks(5);
      chk("crc_beef", crc_ref(16'hBEEF), 8'h92);
      chk("crc_6666", crc_ref(16'h6666), 8'h93);
      do_write(ADDR, 8'hFD, 0, 16'hBEEF, 16'h6666);
      do_read(ADDR, 1, 0);
      do_write(ADDR, 8'hF6, 0, 16'h1111, 16'h2222);
      wait_meas;
      do_read(ADDR, 6, 0);
      do_write(7'h45, 8'hFD, 0, 16'h0, 16'h0);
      do_write(ADDR, 8'h12, 0, 16'h0, 16'h0);
      do_write(ADDR, 8'hE0, 1, 16'hBEEF, 16'h1234);
      wait_meas;
      i2c_start;
      write_byte({ADDR, 1'b1}, r);
      chk("mid_addr", r, 0);
      for (int i = 2; i >= 0; i--) bit_io(1'b1, bits[i]);
      chk("mid_bits", bits, 3'b101);
      m_sda = 0;
      clks(H);
      m_scl = 1;
      clks(H);
      m_sda = 1;
      clks(3);
      chk("mid_stop_sda", sda_out, 1);
      chk("mid_stop_ready", data_ready, m_ready);
      clks(H);
      do_write(ADDR, 8'hE0, 0, 16'h5A5A, 16'hC3C3);
      wait_meas;
      i2c_start;
      for (int i = 7; i >= 0; i--) bit_io(i == 0 ? 1'b1 : ADDR[i-1], r);
      m_sda = 1;
      clks(H - 2);
      m_scl = 1;
      clks(H / 2);
      chk("ack_drv", bus_sda, 0);
      rst = 1;
      #1;
      chk("rrst_sda", sda_out, 1);
      chk("rrst_ready", data_ready, 0);
      chk("rrst_busy", meas_busy, 0);
      m_ready = 0;
      m_busy = 0;
      m_cmd = 0;
      clks(3);
      rst = 0;
      clks(H);
      do_write(ADDR, 8'hF6, 0, 16'h0F0F, 16'h8001);
      wait_meas;
      do_read(ADDR, 6, 0);
      for (int it = 0; it < 10; it++) begin
         logic [6:0] a;
         logic [7:0] c;
         int sel;
         sel = $urandom_range(0, 3);
         a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ADDR;
         c = sel == 0 ? 8'hFD : sel == 1 ? 8'hF6 : sel == 2 ? 8'hE0 : 8'($urandom);
         do_write(a, c, 1'($urandom), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            if ($urandom_range(0, 1) == 1) do_read(ADDR, 1, 0);
            else do_write(ADDR, 8'hFD, 0, 16'($urandom), 16'($urandom));
         end
         wait_meas;
         a = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ADDR;
         do_read(a, $urandom_range(1, 8), $urandom_range(0, 1) == 1 ? $urandom_range(1, 3) : 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
